// File: rtl/spad_sram_ctrl.sv
// Scratchpad SRAM controller: fixed-priority (BE > VC > SA) arbiter driving
// one bank access per grant, with read-data capture and response pulses.
module spad_sram_ctrl #(
  parameter int READ_LAT = 2,
  parameter int SLOT_W   = 32,
  parameter int DATA_W   = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sram_req_be_i,
  input  logic              sram_req_vc_i,
  input  logic              sram_req_sa_i,
  input  logic              vc_write_i,
  input  logic              sa_write_i,
  input  logic [SLOT_W-1:0] be_slot_i,
  input  logic [SLOT_W-1:0] vc_slot_i,
  input  logic [SLOT_W-1:0] sa_slot_i,
  input  logic [DATA_W-1:0] xbar_out_i,
  output logic              sram_reserved_be_o,
  output logic              sram_reserved_vc_o,
  output logic              sram_reserved_sa_o,
  output logic              bank_en_o,
  output logic              bank_we_o,
  output logic [SLOT_W-1:0] bank_slot_o,
  output logic [DATA_W-1:0] bank_wdata_o,
  input  logic [DATA_W-1:0] bank_rdata_i,
  output logic [DATA_W-1:0] xbar_in_vc_o,
  output logic [DATA_W-1:0] xbar_in_sa_o,
  output logic [1:0]        resp_valid_o,
  output logic              resp_ready_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              be_wr_done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    O_NONE,
    O_BE,
    O_VC,
    O_SA
  } owner_e;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   xvc_q, xvc_d;
  logic [DATA_W-1:0]   xsa_q, xsa_d;

  logic                arb_req;
  owner_e              arb_owner;
  logic                arb_wr;
  logic [SLOT_W-1:0]   arb_slot;

  // Fixed priority: a lower requester only wins when all higher ones are idle.
  always_comb begin
    arb_req   = sram_req_be_i | sram_req_vc_i | sram_req_sa_i;
    arb_owner = O_NONE;
    arb_wr    = 1'b0;
    arb_slot  = '0;
    if (sram_req_be_i) begin
      arb_owner = O_BE;
      arb_wr    = 1'b1;
      arb_slot  = be_slot_i;
    end else if (sram_req_vc_i) begin
      arb_owner = O_VC;
      arb_wr    = vc_write_i;
      arb_slot  = vc_slot_i;
    end else if (sram_req_sa_i) begin
      arb_owner = O_SA;
      arb_wr    = sa_write_i;
      arb_slot  = sa_slot_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= O_NONE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      slot_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      xvc_q   <= '0;
      xsa_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      slot_q  <= slot_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      xvc_q   <= xvc_d;
      xsa_q   <= xsa_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    slot_d  = slot_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    xvc_d   = xvc_q;
    xsa_d   = xsa_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (arb_req) begin
          state_d = S_ACCESS;
          owner_d = arb_owner;
          wr_d    = arb_wr;
          slot_d  = arb_slot;
          wdata_d = xbar_out_i;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 3'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT) begin
          state_d = S_RESP;
          rdata_d = bank_rdata_i;
          if (owner_q == O_VC) xvc_d = bank_rdata_i;
          if (owner_q == O_SA) xsa_d = bank_rdata_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sram_reserved_be_o = 1'b0;
    sram_reserved_vc_o = 1'b0;
    sram_reserved_sa_o = 1'b0;
    bank_en_o          = 1'b0;
    bank_we_o          = 1'b0;
    bank_slot_o        = '0;
    bank_wdata_o       = '0;
    resp_valid_o       = 2'b00;
    be_wr_done_o       = 1'b0;
    resp_ready_o       = (state_q == S_IDLE);
    if (state_q == S_ACCESS) begin
      bank_en_o    = 1'b1;
      bank_we_o    = wr_q;
      bank_slot_o  = slot_q;
      bank_wdata_o = wdata_q;
      unique case (owner_q)
        O_BE:    sram_reserved_be_o = 1'b1;
        O_VC:    sram_reserved_vc_o = 1'b1;
        O_SA:    sram_reserved_sa_o = 1'b1;
        default: ;
      endcase
    end
    if (state_q == S_RESP) begin
      unique case (owner_q)
        O_BE:    be_wr_done_o = 1'b1;
        O_VC:    resp_valid_o = 2'b10;
        O_SA:    resp_valid_o = 2'b01;
        default: ;
      endcase
    end
  end

  assign xbar_in_vc_o = xvc_q;
  assign xbar_in_sa_o = xsa_q;
  assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_spad_sram_ctrl.sv
// Randomized bench for spad_sram_ctrl against a transaction-level
// schedule model (grant cycle, access cycle, response cycle).
module tb_spad_sram_ctrl;
  localparam int LAT  = 2;
  localparam int SW   = 32;
  localparam int DW   = 64;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_be, req_vc, req_sa;
  logic          vc_wr, sa_wr;
  logic [SW-1:0] be_slot, vc_slot, sa_slot;
  logic [DW-1:0] xbar_out, bank_rdata;
  logic          res_be, res_vc, res_sa;
  logic          bank_en, bank_we;
  logic [SW-1:0] bank_slot;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] xin_vc, xin_sa, resp_rdata;
  logic [1:0]    resp_valid;
  logic          resp_ready, be_wr_done;

  spad_sram_ctrl #(.READ_LAT(LAT), .SLOT_W(SW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sram_req_be_i(req_be), .sram_req_vc_i(req_vc),
    .sram_req_sa_i(req_sa),
    .vc_write_i(vc_wr), .sa_write_i(sa_wr),
    .be_slot_i(be_slot), .vc_slot_i(vc_slot),
    .sa_slot_i(sa_slot),
    .xbar_out_i(xbar_out),
    .sram_reserved_be_o(res_be),
    .sram_reserved_vc_o(res_vc),
    .sram_reserved_sa_o(res_sa),
    .bank_en_o(bank_en), .bank_we_o(bank_we),
    .bank_slot_o(bank_slot), .bank_wdata_o(bank_wdata),
    .bank_rdata_i(bank_rdata),
    .xbar_in_vc_o(xin_vc), .xbar_in_sa_o(xin_sa),
    .resp_valid_o(resp_valid), .resp_ready_o(resp_ready),
    .resp_rdata_o(resp_rdata), .be_wr_done_o(be_wr_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Current transaction: owner 0=BE 1=VC 2=SA
  bit            cv;
  int            c_own, c_acc, c_resp;
  bit            c_wr;
  logic [SW-1:0] c_slot;
  logic [DW-1:0] c_wdata, c_rdata;
  logic [DW-1:0] m_rdata, m_xvc, m_xsa;

  bit            pend[3], gnt[3], rwr[3], lng[3];
  int            drop_at[3];
  logic [SW-1:0] rslot[3];
  logic [DW-1:0] rdat[3];

  task automatic check_cycle(input int n);
    bit         acc, rsp;
    logic [2:0] exp_res;
    logic [1:0] exp_rv;
    acc = cv && (n == c_acc);
    rsp = cv && (n == c_resp);
    if (rsp && !c_wr) begin
      m_rdata = c_rdata;
      if (c_own == 1) m_xvc = c_rdata;
      if (c_own == 2) m_xsa = c_rdata;
    end
    exp_res = acc ? (3'b100 >> c_own) : 3'b000;
    exp_rv  = 2'b00;
    if (rsp && c_own == 1) exp_rv = 2'b10;
    if (rsp && c_own == 2) exp_rv = 2'b01;
    chk("reserved", {res_be, res_vc, res_sa}, exp_res);
    chk("bank_en", bank_en, acc);
    if (acc) begin
      chk("bank_we", bank_we, c_wr);
      chk("bank_slot", bank_slot, c_slot);
      chk("bank_wdata", bank_wdata, c_wdata);
    end
    chk("resp_valid", resp_valid, exp_rv);
    chk("be_wr_done", be_wr_done, rsp && c_own == 0);
    chk("resp_ready", resp_ready, !cv);
    chk("resp_rdata", resp_rdata, m_rdata);
    chk("xbar_in_vc", xin_vc, m_xvc);
    chk("xbar_in_sa", xin_sa, m_xsa);
    if (rsp) cv = 1'b0;
  endtask

  task automatic drive_reqs();
    req_be  = pend[0];
    req_vc  = pend[1];
    req_sa  = pend[2];
    be_slot = rslot[0];
    vc_slot = rslot[1];
    sa_slot = rslot[2];
    vc_wr   = rwr[1];
    sa_wr   = rwr[2];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_reserved"}, {res_be, res_vc, res_sa}, 3'b000);
    chk({tag, "_bank_en"}, bank_en, 1'b0);
    chk({tag, "_resp_valid"}, resp_valid, 2'b00);
    chk({tag, "_be_wr_done"}, be_wr_done, 1'b0);
    chk({tag, "_resp_ready"}, resp_ready, 1'b1);
    chk({tag, "_resp_rdata"}, resp_rdata, '0);
    chk({tag, "_xbar_in_vc"}, xin_vc, '0);
    chk({tag, "_xbar_in_sa"}, xin_sa, '0);
  endtask

  initial begin
    int w;
    cv = 0; m_rdata = '0; m_xvc = '0; m_xsa = '0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; gnt[i] = 0; rwr[i] = 0; lng[i] = 0;
      drop_at[i] = 0; rslot[i] = '0; rdat[i] = '0;
    end
    drive_reqs();
    xbar_out = '0;
    bank_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      check_cycle(n);

      // Occasional asynchronous reset while a read is waiting on the bank
      if (cv && !c_wr && n > c_acc && n < c_resp &&
          $urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        cv = 0; m_rdata = '0; m_xvc = '0; m_xsa = '0;
        for (int i = 0; i < 3; i++) begin
          pend[i] = 0; gnt[i] = 0;
        end
        drive_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end

      for (int i = 0; i < 3; i++) begin
        if (pend[i] && gnt[i] && n >= drop_at[i]) begin
          pend[i] = 0;
          gnt[i]  = 0;
        end
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1;
          gnt[i]   = 0;
          rslot[i] = $urandom;
          rdat[i]  = {$urandom, $urandom};
          rwr[i]   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          lng[i]   = ($urandom_range(0, 7) == 0);
        end
      end
      if (n == 0) begin
        pend[0] = 1; gnt[0] = 0; lng[0] = 0; rwr[0] = 1;
        rslot[0] = 32'h0000_000F;
        rdat[0]  = 64'hA5A5_A5A5_A5A5_A5A5;
      end

      bank_rdata = {$urandom, $urandom};
      if (cv && !c_wr && n == c_acc + LAT) c_rdata = bank_rdata;

      w = -1;
      if (!cv) begin
        for (int i = 2; i >= 0; i--)
          if (pend[i]) w = i;
      end
      xbar_out = (w >= 0) ? rdat[w] : {$urandom, $urandom};
      if (w >= 0) begin
        cv      = 1;
        c_own   = w;
        c_wr    = rwr[w];
        c_slot  = rslot[w];
        c_wdata = rdat[w];
        c_acc   = n + 1;
        c_resp  = rwr[w] ? n + 2 : n + 2 + LAT;
        gnt[w]  = 1;
        drop_at[w] = n + 2 + (lng[w] ? 1 : 0);
        lng[w]  = 0;
      end
      drive_reqs();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/spad_sram_ctrl.md
# spad_sram_ctrl

Arbitrating SRAM control unit for one scratchpad, downstream of the backend prefetcher, frontend VC and frontend SA. Grants exclusive SRAM access by fixed priority (BE > VC > SA) and drives one bank access per grant. For reads it captures bank data after a fixed latency and returns it on the crossbar input and response bus. For writes it commits the crossbar output into the selected slots.

## Interface
- READ_LAT, 2: bank read latency in cycles, legal range 1..4.
- CLK  in  1  clock.
- nRST  in  1  reset; one clock; reset is asynchronous and active-low.
- sram_req_be / sram_req_vc / sram_req_sa  in  1 each  level request from each requester.
- vc_write / sa_write  in  1 each  request is a write (BE is always write).
- be_slot / vc_slot / sa_slot  in  slot_mask  `.slot` field of each requester's xbar descriptor.
- xbar_out  in  scpad_data  crossbar output, write data of the requester.
- sram_reserved_be / sram_reserved_vc / sram_reserved_sa  out  1 each  grant confirmation.
- bank_en, bank_we  out  1 each  bank access strobe / write enable.
- bank_slot  out  slot_mask  slots accessed.
- bank_wdata  out  scpad_data  write data.
- bank_rdata  in  scpad_data  read data, valid READ_LAT cycles after the bank_en cycle.
- xbar_in_vc / xbar_in_sa  out  scpad_data  read data toward the crossbar.
- resp_valid  out  2  [1]=VC, [0]=SA completion.
- resp_ready  out  1  controller idle.
- resp_rdata  out  scpad_data  read data.
- be_wr_done  out  1  BE write committed.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- Arbitration occurs only in IDLE and RESP. On the sampling edge:
  - Owner is the highest-priority asserted request (BE > VC > SA).
  - Latch owner, write, owner's slot, and xbar_out.
  - Go to ACCESS.
  - With no request, go or stay IDLE.
- ACCESS, one cycle:
  - sram_reserved_<owner>=1.
  - bank_en=1, bank_we=latched write, bank_slot/bank_wdata=latched values.
  - Next state: write → RESP; read → WAIT with cnt=1.
- WAIT:
  - cnt increments each cycle.
  - When cnt==READ_LAT, capture bank_rdata into the rdata register and go to RESP.
- RESP, one cycle:
  - Read by VC: resp_valid[1]=1, xbar_in_vc=resp_rdata=captured data.
  - Read by SA: resp_valid[0]=1, xbar_in_sa=resp_rdata=captured data.
  - Write by VC/SA: resp_valid bit set, rdata holds its last value.
  - Write by BE: be_wr_done=1.
  - A new grant may be sampled in this cycle.
- Outputs are decoded from state and latched registers. The rdata register, xbar_in_vc, xbar_in_sa and resp_rdata hold their value between transactions.
- resp_ready=1 only in IDLE.
- Requester rules:
  - Hold sram_req and valid xbar_out/slot until sram_reserved is seen.
  - Deassert sram_req in the following cycle; otherwise the request is re-granted as a new transaction.
- Priority is strictly fixed; SA can starve under continuous BE/VC traffic. This is accepted.
- Simultaneous requests: only the winner is latched; losers stay pending and are re-evaluated at the next IDLE/RESP edge.
- Reset (asynchronous, mid-operation included):
  - State goes to IDLE, cnt and all latched registers go to 0.
  - All outputs go to 0 immediately, except resp_ready=1.
  - Any in-flight read response is discarded.

## Timing
- Cycle 0 is the IDLE/RESP cycle in which the request is sampled.
- Write: ACCESS in c1, RESP in c2. Back-to-back writes issue bank_en every 2 cycles.
- Read: ACCESS c1, WAIT c2..c(1+READ_LAT), RESP c(2+READ_LAT). Request-to-response latency is READ_LAT+2 cycles (4 at default).
- sram_reserved is a one-cycle pulse, coincident with bank_en.
- resp_valid, be_wr_done: one-cycle pulses.
- Counter is 3 bits; no wrap occurs within the legal READ_LAT range.

## Test plan
- Reset, then a BE write with be_slot=0x0000_000F, xbar_out=0xA5.. → c1: sram_reserved_be=1, bank_en=1, bank_we=1, bank_slot=0xF, bank_wdata=0xA5..; c2: be_wr_done=1, resp_valid=00; c3: resp_ready=1.
- VC read, READ_LAT=2, bank_rdata=0x1234.. in c3 → c4: resp_valid=10, xbar_in_vc=resp_rdata=0x1234..; xbar_in_sa unchanged.
- BE, VC and SA all request in c0, each dropping its request after its reservation → grants BE (c1), VC (c3), SA (c5); each sram_reserved pulses once.
- SA read in flight while VC requests during WAIT → VC not granted until the SA RESP cycle; VC ACCESS immediately follows SA RESP; SA response has resp_valid=01.
- nRST asserted during WAIT of an SA read → bank_en=0 and resp_valid=00 immediately; after release, no resp_valid pulse, state IDLE, resp_ready=1.
- VC holds sram_req for 2 cycles after its reservation → second grant issued (second sram_reserved_vc pulse in c3); confirms the re-grant rule.
